// File: rtl/debounce_pkg.sv
// Shared state encodings for the push-button debouncer.
package debounce_pkg;
  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE      = 2'b00;
  localparam logic [STATE_W-1:0] CHK_PRESS = 2'b01;
  localparam logic [STATE_W-1:0] HELD      = 2'b10;
  localparam logic [STATE_W-1:0] CHK_REL   = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = IDLE,
    ST_CHK_PRESS = CHK_PRESS,
    ST_HELD      = HELD,
    ST_CHK_REL   = CHK_REL
  } state_t;
endpackage

// File: rtl/debounce_pulse_if.sv
// Button-in / debounced-out signal bundle between the board logic and the debouncer.
interface debounce_pulse_if;
  import debounce_pkg::*;

  logic               btn_in;
  logic               pulse;
  logic               level;
  logic [STATE_W-1:0] state_o;

  modport master (output btn_in, input pulse, input level, input state_o);
  modport slave  (input btn_in, output pulse, output level, output state_o);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit board input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1_reg;
  logic q_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg <= 1'b0;
      q_reg  <= 1'b0;
    end else begin
      s1_reg <= d;
      q_reg  <= s1_reg;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/debounce_pulse.sv
// Debounces a raw button and emits one enable pulse per accepted press plus a debounced level.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  debounce_pulse_if.slave  bus
);
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             btn_s;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pulse_reg, pulse_next;
  logic             level_reg, level_next;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.btn_in),
    .q     (btn_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
      level_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
      level_reg <= level_next;
    end
  end

  // pulse defaults low, so it can only be high for the single cycle after acceptance
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pulse_next = 1'b0;
    level_next = level_reg;
    case (state_reg)
      ST_IDLE: begin
        if (btn_s) begin
          state_next = ST_CHK_PRESS;
          cnt_next   = '0;
        end
      end
      ST_CHK_PRESS: begin
        if (!btn_s) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_HELD;
          pulse_next = 1'b1;
          level_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!btn_s) begin
          state_next = ST_CHK_REL;
          cnt_next   = '0;
        end
      end
      ST_CHK_REL: begin
        if (btn_s) begin
          state_next = ST_HELD;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_IDLE;
          level_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.pulse   = pulse_reg;
  assign bus.level   = level_reg;
  assign bus.state_o = state_reg;
endmodule

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Conditions a raw push-button input for the toggle flip-flop stage (FlipFlopD with D = ~Q).
- Synchronises the button into clk and rejects bounce by requiring STABLE_CYCLES consecutive equal samples.
- Emits a single-cycle `pulse` per qualified press, which drives the flip-flop's enable, plus a debounced `level`.
- Sits directly upstream of the toggle stage on the lab board.

Parameters:
- STABLE_CYCLES, 4, number of consecutive synchronised samples required to accept a press or release (≥1; 4 for simulation, 500000 on board).
- CNT_W, $clog2(STABLE_CYCLES+1), width of the qualification counter (localparam, derived, not overridable).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- btn_in  input  1  raw, asynchronous, bouncing button (1 = pressed).
- pulse  output  1  registered, high for exactly one clk cycle per accepted press.
- level  output  1  registered debounced button state.
- state_o  output  2  current FSM state, for debug and verification.

Behaviour:
- Reset (async, active-high): sync FFs = 0, cnt = 0, state = IDLE, pulse = 0, level = 0, state_o = 2'b00. Takes effect without waiting for clk; held while reset = 1.
- Synchroniser: 2-FF chain btn_in -> s1 -> btn_s, reset to 0; 2-edge latency. FSM reads only btn_s.
- State encoding: IDLE = 00, CHK_PRESS = 01, HELD = 10, CHK_REL = 11.
- IDLE: btn_s = 1 -> CHK_PRESS, cnt <= 0; else stay.
- CHK_PRESS:
  - btn_s = 0 -> IDLE (bounce rejected, no pulse).
  - btn_s = 1 and cnt == STABLE_CYCLES-1 -> HELD, pulse <= 1, level <= 1.
  - Otherwise cnt <= cnt+1.
- HELD: pulse <= 0 every cycle; btn_s = 0 -> CHK_REL, cnt <= 0.
- CHK_REL:
  - btn_s = 1 -> HELD (no new pulse).
  - btn_s = 0 and cnt == STABLE_CYCLES-1 -> IDLE, level <= 0.
  - Otherwise cnt <= cnt+1.
- Latency: the first edge sampling btn_in = 1 is edge E0. With btn_in stable from E0, pulse and level rise at edge E(STABLE_CYCLES+2). Release is symmetric; level falls at the same edge offset.
- pulse is never high in two consecutive cycles and is never asserted outside the IDLE->…->HELD path.
- cnt saturates by construction (never exceeds STABLE_CYCLES-1); there is no wrap-around.
- A press held indefinitely yields exactly one pulse.
- Reset mid-operation: outputs drop to 0 at once. If btn_in is still high after reset release, a full new qualification runs and produces one new pulse.
- STABLE_CYCLES = 1: accept on the first cycle in CHK_PRESS/CHK_REL; the design must stay legal.

Decomposition:
- Package debounce_pkg: the four state encodings as localparams, plus STATE_W = 2.
- Sub-module sync_2ff (clk, reset, d, q): the two-flop synchroniser, reusable for other board inputs.
- FSM, counter and output registers stay in debounce_pulse.

Test Plan (STABLE_CYCLES = 4, clk period 10):
- Reset with btn_in = 1: pulse, level and state_o read 0 while reset = 1. Release reset with btn_in held high -> one pulse at the 7th edge after release, then pulse = 0, level = 1.
- Clean press: btn_in 0->1, held 20 cycles -> pulse high for exactly one cycle at E6 (edges counted from E0), level = 1 from E6, state_o = 10, no further pulses.
- Press bounce: btn_in high 2 cycles, low 1, high 2, then low -> pulse never asserted, level stays 0, state_o returns to 00.
- Release bounce: from HELD, btn_in low 2 cycles then high -> level stays 1 with no second pulse. Then btn_in low 10 cycles -> level = 0 at E6 after the low edge, state_o = 00.
- Reset mid-HELD: assert reset between clock edges -> level and pulse go to 0 before the next edge.
- Integration: pulse drives the enable of FlipFlopD (D = ~Q). Three clean presses separated by 15 low cycles -> Q goes 0 -> 1 -> 0 -> 1, one toggle per press.
